// File: rtl/pc_fetch_unit_pkg.sv
// ============================================================================
//  Module  : pc_fetch_unit_pkg
//  Purpose : Shared types and constants for the fetch unit and the next-PC
//            logic: fetch state encoding, PC increment, default reset PC and
//            the address / instruction widths both blocks agree on.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_fetch_unit_pkg;

  localparam int ADDR_WIDTH  = 64;
  localparam int INSTR_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] DEFAULT_RESET_PC = 64'h0;

  // Byte distance between consecutive instruction words.
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_unit_fetch_queue.sv
// ============================================================================
//  Module  : fetch_queue
//  Purpose : DEPTH-entry synchronous FIFO holding fetched instructions.
//            Registered storage, head read straight from the array, no
//            write-to-read bypass. Push and pop in the same cycle both take
//            effect, including when the queue is full.
//  Ports   : clk, rst          - clock, asynchronous active-high reset
//            i_push/i_push_data - write an entry
//            i_pop             - drop the head entry
//            i_clear           - empty the queue (wins over push/pop)
//            o_full/o_empty    - status flags
//            o_count           - current occupancy (0..DEPTH)
//            o_head            - head entry data
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  input  logic                   i_clear,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [WIDTH-1:0]       o_head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A full queue can still accept a push when the head leaves in the same
  // cycle; the write lands in the slot being vacated.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
//  Module  : pc_fetch_unit
//  Purpose : Program-counter register and in-order instruction-fetch
//            sequencer. Issues word fetches over a valid/ready request
//            channel, queues responses and hands them to decode. A decode
//            handshake with Redirect set clears the queue, drops in-flight
//            responses and restarts fetch at NextPC.
//  Ports   : CLK, Reset                - clock, async active-high reset
//            NextPC, Redirect          - redirect target / taken-branch flag
//            imem_req_valid/addr/ready - fetch request channel
//            imem_rsp_valid/data       - fetch response (never stalled)
//            instr_valid/out/ready     - decode handshake
//            CurrentPC                 - PC of the queue head
//            fetch_count, flush_count, stall_cycles
//                                      - performance counters, present only
//                                        when FETCH_PERF_CNT_EN is defined
//  Config  : `define FETCH_PERF_CNT_EN to add the saturating counters.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_WIDTH,
  parameter int                INSTR_W  = INSTR_WIDTH,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int                QDEPTH   = 2
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [ADDR_W-1:0]  NextPC,
  input  logic               Redirect,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  CurrentPC,
  input  logic               instr_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        flush_count,
  output logic [31:0]        stall_cycles
`endif
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(PC_STEP);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_current_pc;
  logic [CNT_W-1:0]  r_outstanding;

  logic [CNT_W-1:0]  w_occupancy;
  logic [CNT_W:0]    w_credit_used;
  logic              w_q_full;
  logic              w_q_empty;
  logic              w_req_valid;
  logic              w_accept;
  logic              w_handshake;
  logic              w_redirect;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_target;
  logic              w_unused_bits;

  // Every request in flight already owns a queue slot, so the queue can
  // never overflow and responses never need back-pressure.
  assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_occupancy};
  assign w_req_valid   = (r_state == ST_RUN) && !w_q_full &&
                         (w_credit_used < (CNT_W+1)'(QDEPTH));
  assign w_accept      = w_req_valid & imem_req_ready;

  assign w_handshake = instr_valid & instr_ready;
  assign w_redirect  = w_handshake & Redirect;

  // Responses are kept only while running normally; during FLUSH (and in
  // the redirect cycle itself) they belong to the abandoned path.
  assign w_push = imem_rsp_valid & (r_state == ST_RUN) & ~w_redirect;
  assign w_pop  = w_handshake & ~w_redirect;

  assign w_target      = {NextPC[ADDR_W-1:2], 2'b00};
  assign w_unused_bits = ^NextPC[1:0];

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign CurrentPC      = r_current_pc;
  assign instr_valid    = ~w_q_empty;

  fetch_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (INSTR_W)
  ) u_fetch_queue (
    .clk         (CLK),
    .rst         (Reset),
    .i_push      (w_push),
    .i_push_data (imem_rsp_data),
    .i_pop       (w_pop),
    .i_clear     (w_redirect),
    .o_full      (w_q_full),
    .o_empty     (w_q_empty),
    .o_count     (w_occupancy),
    .o_head      (instr_out)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state       <= ST_BOOT;
      r_fetch_pc    <= RESET_PC;
      r_current_pc  <= RESET_PC;
      r_outstanding <= '0;
    end else begin
      // A request accepted in the redirect cycle is still counted so that
      // its response is recognised and dropped during FLUSH.
      r_outstanding <= r_outstanding + CNT_W'(w_accept) - CNT_W'(imem_rsp_valid);

      case (r_state)
        ST_BOOT: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_redirect) begin
            r_state      <= ST_FLUSH;
            r_fetch_pc   <= w_target;
            r_current_pc <= w_target;
          end else begin
            if (w_accept) begin
              r_fetch_pc <= r_fetch_pc + c_PC_STEP;
            end
            // Fetch is in order, so the next head is always one word on.
            if (w_pop) begin
              r_current_pc <= r_current_pc + c_PC_STEP;
            end
          end
        end
        ST_FLUSH: begin
          // fetch_pc already holds the redirect target; no requests are
          // issued here so it cannot move.
          if (r_outstanding == '0) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic w_stall;

  assign w_stall = (r_state == ST_RUN) && (!w_req_valid || !imem_req_ready);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      fetch_count  <= '0;
      flush_count  <= '0;
      stall_cycles <= '0;
    end else begin
      if (w_accept && (fetch_count != '1)) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (w_redirect && (flush_count != '1)) begin
        flush_count <= flush_count + 32'd1;
      end
      if (w_stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer; sits directly upstream of the next-PC logic.
- Owns CurrentPC and issues in-order word fetches to instruction memory over a valid/ready request channel.
- Buffers returned instructions in a small queue and hands them to decode with a valid/ready handshake.
- Takes the next-PC logic's NextPC back as a redirect target when a taken branch retires.

Parameters:
- ADDR_W, 64, PC / address width
- INSTR_W, 32, instruction width
- RESET_PC, 64'h0, PC loaded on reset
- QDEPTH, 2, instruction queue depth and maximum in-flight credit (power of 2, >= 2)

Ports:
- CLK  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- NextPC  in  ADDR_W  target from next-PC logic
- Redirect  in  1  retiring instruction is a taken branch; sampled only on a decode handshake
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  ADDR_W  fetch address, word aligned
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response valid; in order, >= 1 cycle after request accept; never back-pressured
- imem_rsp_data  in  INSTR_W  fetched instruction
- instr_valid  out  1  queue head valid
- instr_out  out  INSTR_W  queue head instruction
- CurrentPC  out  ADDR_W  PC of queue head (feeds next-PC logic)
- instr_ready  in  1  decode consumes head

Behaviour:
- Clock and reset: one clock, CLK; Reset asynchronous, active-high.
- Reset values:
  - fetch_pc = RESET_PC, CurrentPC = RESET_PC.
  - imem_req_valid = 0, instr_valid = 0, instr_out = 0.
  - Queue empty, outstanding = 0, state = BOOT.
- States and transitions:
  - BOOT: one cycle, no request; then RUN.
  - RUN: imem_req_valid = 1 iff (outstanding + occupancy) < QDEPTH.
    - On req accept: outstanding++, fetch_pc += 4 (wraps mod 2^ADDR_W).
    - On rsp: push into queue, outstanding--.
  - FLUSH: entered on a redirect.
    - imem_req_valid = 0.
    - Incoming responses are discarded, outstanding-- each.
    - When outstanding == 0 (including the entry cycle if already 0): next cycle is RUN with fetch_pc = latched target.
- Redirect rule: decode handshake (instr_valid & instr_ready) with Redirect = 1 →
  - Queue cleared.
  - fetch_pc and CurrentPC <= NextPC[ADDR_W-1:2] concatenated with 2'b00.
  - A request accepted in that same cycle is counted in outstanding and discarded later.
  - State goes to FLUSH.
- Handshake without redirect: pop the head; CurrentPC becomes the PC of the new head (old CurrentPC + 4).
- CurrentPC semantics: CurrentPC always equals the PC of the head entry, or of the next instruction to arrive when the queue is empty.
- Queue: registered outputs; push and pop in the same cycle both succeed. A response arriving while the queue is empty becomes visible the following cycle (no bypass).
- Redirect outside a handshake: ignored.
- Request stability: imem_req_valid and imem_req_addr hold stable until accepted, except when removed by a redirect.
- Reset mid-operation: everything returns to reset values immediately. Responses arriving after Reset deasserts for pre-reset requests are a protocol violation (memory must also be reset).

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds the following outputs, all cleared by Reset and saturating at all-ones:
  - fetch_count [31:0]: accepted requests.
  - flush_count [31:0]: redirects.
  - stall_cycles [31:0]: cycles in RUN with imem_req_valid = 0 or imem_req_ready = 0.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - Fetch state enum (BOOT, RUN, FLUSH).
  - PC increment constant PC_STEP = 4.
  - Default RESET_PC.
  - Address and instruction width constants shared with the next-PC logic.
- Sub-module fetch_queue: QDEPTH-entry synchronous FIFO with push/pop/clear, full/empty and occupancy count.

Test Plan:
- Reset release, memory always ready, 1-cycle latency, instr_ready = 1:
  - Requests at 0x0, 0x4, 0x8, ...
  - First instr_valid exactly 3 cycles after reset deassert.
  - CurrentPC tracks the head.
- instr_ready = 0 held:
  - Exactly QDEPTH = 2 requests issued, then imem_req_valid = 0.
  - Releasing instr_ready resumes requests at 0x8.
- Redirect on the head at PC 0x4 with NextPC = 0x100 while 1 request is outstanding:
  - That response is dropped.
  - Next request addr is 0x100 only after outstanding reaches 0.
  - Next delivered CurrentPC = 0x100.
- Simultaneous push and pop with a full queue under steady 1-cycle memory: one instruction per cycle, no loss, no duplication.
- imem_req_ready low for 5 cycles: imem_req_addr is stable throughout; exactly one accept.
- Wrap-around: RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC → second request address is 0x0.
- Reset asserted mid-FLUSH: outputs return to reset values asynchronously.
